// File: rtl/eq_pkg.sv
// Shared equaliser constants: FSM states, STATUS command bits and
// default band geometry used by the gain bank and the filter bank.
package eq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RAMP  = 2'd2
   } eq_state_t;

   localparam int CMD_COMMIT  = 0;
   localparam int CMD_CLR_ERR = 1;

   localparam int EQ_NUM_BANDS = 10;
   localparam int EQ_GAIN_W    = 8;

endpackage

// File: rtl/eq_gain_ramp.sv
// Single-band slice: moves active toward target by at most step per tick,
// never overshooting and never wrapping.
module eq_gain_ramp #(
   parameter int GAIN_W = 8
) (
   input  logic [GAIN_W-1:0] active,
   input  logic [GAIN_W-1:0] target,
   input  logic [GAIN_W:0]   step,
   input  logic              tick,
   output logic [GAIN_W-1:0] next_active,
   output logic              done
);

   logic [GAIN_W:0] a_x;
   logic [GAIN_W:0] t_x;
   logic [GAIN_W:0] diff;
   logic [GAIN_W:0] sum;
   logic [GAIN_W:0] nxt;

   assign a_x = {1'b0, active};
   assign t_x = {1'b0, target};

   // One extra bit keeps the add/subtract free of wrap-around.
   always_comb begin
      diff = '0;
      sum  = a_x;
      if (t_x > a_x) begin
         diff = t_x - a_x;
         sum  = (diff > step) ? a_x + step : t_x;
      end else if (a_x > t_x) begin
         diff = a_x - t_x;
         sum  = (diff > step) ? a_x - step : t_x;
      end
      nxt = tick ? sum : a_x;
   end

   assign next_active = nxt[GAIN_W-1:0];
   assign done        = (nxt == t_x);

endmodule

// File: rtl/eq_gain_bank.sv
// Equaliser gain bank: host shadow registers, tick-aligned commit to
// target, and per-tick ramping of the active gains feeding the filters.
module eq_gain_bank
   import eq_pkg::*;
#(
   parameter int NUM_BANDS  = EQ_NUM_BANDS,
   parameter int GAIN_W     = EQ_GAIN_W,
   parameter int ADDR_W     = 8,
   parameter int GAIN_RESET = 64,
   parameter int RAMP_STEP  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        we,
   input  logic                        re,
   input  logic [ADDR_W-1:0]           addr,
   input  logic [GAIN_W-1:0]           data_in,
   output logic [GAIN_W-1:0]           data_out,
   output logic                        rd_valid,
   input  logic                        sample_tick,
   output logic [NUM_BANDS*GAIN_W-1:0] gains,
   output logic                        busy,
   output logic                        addr_err
);

   localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(NUM_BANDS);
   localparam logic [GAIN_W-1:0] G_RST    = GAIN_W'(GAIN_RESET);
   localparam logic [GAIN_W:0]   STEP     = (GAIN_W+1)'(RAMP_STEP);

   logic [GAIN_W-1:0] shadow   [NUM_BANDS];
   logic [GAIN_W-1:0] target   [NUM_BANDS];
   logic [GAIN_W-1:0] active   [NUM_BANDS];
   logic [GAIN_W-1:0] next_act [NUM_BANDS];
   logic [NUM_BANDS-1:0] done_v;

   eq_state_t state;
   logic      pending;

   logic is_gain;
   logic is_status;
   logic is_bad;
   logic commit;
   logic clr_err;
   logic pend_n;
   logic done_all;
   logic rtick;
   logic [GAIN_W-1:0] rd_word;

   assign is_gain   = addr < STATUS_A;
   assign is_status = addr == STATUS_A;
   assign is_bad    = addr > STATUS_A;
   assign commit    = we && is_status && data_in[CMD_COMMIT];
   assign clr_err   = we && is_status && data_in[CMD_CLR_ERR];
   assign pend_n    = pending | commit;
   assign done_all  = &done_v;
   assign rtick     = sample_tick && (state == ST_RAMP);

   for (genvar k = 0; k < NUM_BANDS; k++) begin : g_band
      eq_gain_ramp #(.GAIN_W(GAIN_W)) u_ramp (
         .active      (active[k]),
         .target      (target[k]),
         .step        (STEP),
         .tick        (rtick),
         .next_active (next_act[k]),
         .done        (done_v[k])
      );
      assign gains[k*GAIN_W +: GAIN_W] = active[k];
   end

   always_comb begin
      rd_word = '0;
      if (is_status) begin
         rd_word = GAIN_W'({addr_err, pending, state});
      end else begin
         for (int k = 0; k < NUM_BANDS; k++) begin
            if (addr == ADDR_W'(k)) rd_word = shadow[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_BANDS; k++) shadow[k] <= G_RST;
         data_out <= '0;
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         rd_valid <= re;
         if (re) data_out <= rd_word;
         if (we && is_gain) begin
            for (int k = 0; k < NUM_BANDS; k++) begin
               if (addr == ADDR_W'(k)) shadow[k] <= data_in;
            end
         end
         if ((we || re) && is_bad) addr_err <= 1'b1;
         else if (clr_err)         addr_err <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_BANDS; k++) begin
            target[k] <= G_RST;
            active[k] <= G_RST;
         end
         state   <= ST_IDLE;
         pending <= 1'b0;
         busy    <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (commit) begin
                  state <= ST_ARMED;
                  busy  <= 1'b1;
               end
            end
            ST_ARMED: begin
               if (sample_tick) begin
                  for (int k = 0; k < NUM_BANDS; k++) target[k] <= shadow[k];
                  if (RAMP_STEP == 0) begin
                     for (int k = 0; k < NUM_BANDS; k++) active[k] <= shadow[k];
                     state   <= pending ? ST_ARMED : ST_IDLE;
                     busy    <= pending;
                     pending <= 1'b0;
                  end else begin
                     state <= ST_RAMP;
                  end
               end
            end
            ST_RAMP: begin
               pending <= pend_n;
               if (sample_tick) begin
                  for (int k = 0; k < NUM_BANDS; k++) active[k] <= next_act[k];
                  if (done_all) begin
                     state   <= pend_n ? ST_ARMED : ST_IDLE;
                     busy    <= pend_n;
                     pending <= 1'b0;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eq_gain_bank.sv
// Randomised and directed bench for eq_gain_bank against a
// behavioural register/ramp model.
module tb_eq_gain_bank;

   localparam int NB   = 10;
   localparam int GW   = 8;
   localparam int AW   = 8;
   localparam int STEP = 4;
   localparam int GR   = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic we = 1'b0;
   logic re = 1'b0;
   logic sample_tick = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [GW-1:0] data_in = '0;
   logic [GW-1:0] data_out;
   logic rd_valid;
   logic busy;
   logic addr_err;
   logic [NB*GW-1:0] gains;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   int sh [NB];
   int tg [NB];
   int ac [NB];
   int m_st;
   bit m_pend;
   bit m_err;
   bit m_rv;
   int m_dout;

   always #5 clk = ~clk;

   eq_gain_bank #(
      .NUM_BANDS(NB), .GAIN_W(GW), .ADDR_W(AW),
      .GAIN_RESET(GR), .RAMP_STEP(STEP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr),
      .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
      .sample_tick(sample_tick), .gains(gains), .busy(busy),
      .addr_err(addr_err)
   );

   function automatic void chk(string nm, logic [95:0] act, logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NB; k++) begin
         sh[k] = GR;
         tg[k] = GR;
         ac[k] = GR;
      end
      m_st = 0;
      m_pend = 0;
      m_err = 0;
      m_rv = 0;
      m_dout = 0;
   endfunction

   function automatic logic [NB*GW-1:0] exp_gains();
      logic [NB*GW-1:0] v;
      v = '0;
      for (int k = 0; k < NB; k++) v[k*GW +: GW] = GW'(ac[k]);
      return v;
   endfunction

   function automatic void model(bit w, bit r, int a, int d, bit t);
      bit commit;
      bit settled;
      int dl;
      commit = w && a == NB && d[0];
      if (r) begin
         m_rv = 1;
         if (a < NB) m_dout = sh[a];
         else if (a == NB) m_dout = m_err * 8 + m_pend * 4 + m_st;
         else m_dout = 0;
      end else begin
         m_rv = 0;
      end
      case (m_st)
         0: if (commit) m_st = 1;
         1: if (t) begin
            tg = sh;
            m_st = 2;
         end
         default: begin
            m_pend = m_pend | commit;
            if (t) begin
               settled = 1;
               for (int k = 0; k < NB; k++) begin
                  dl = tg[k] - ac[k];
                  if (dl > STEP) ac[k] += STEP;
                  else if (dl < -STEP) ac[k] -= STEP;
                  else ac[k] = tg[k];
                  if (ac[k] != tg[k]) settled = 0;
               end
               if (settled) begin
                  m_st = m_pend ? 1 : 0;
                  m_pend = 0;
               end
            end
         end
      endcase
      if (w && a < NB) sh[a] = d;
      if ((w || r) && a > NB) m_err = 1;
      else if (w && a == NB && d[1]) m_err = 0;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("gains", gains, exp_gains());
         chk("busy", busy, m_st != 0);
         chk("addr_err", addr_err, m_err);
         chk("rd_valid", rd_valid, m_rv);
         if (m_rv) chk("data_out", data_out, m_dout);
      end
   end

   task automatic cyc(input bit w, input bit r, input int a, input int d, input bit t);
      we = w;
      re = r;
      addr = AW'(a);
      data_in = GW'(d);
      sample_tick = t;
      @(posedge clk);
      model(w, r, a, d, t);
      @(negedge clk);
   endtask

   initial begin
      logic [NB*GW-1:0] all40;
      logic [NB*GW-8-1:0] rest40;
      int wa;
      int wd;
      all40 = {NB{8'h40}};
      rest40 = {(NB-1){8'h40}};
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
      chk("reset_gains", gains, all40);
      chk("reset_busy", busy, 1'b0);

      for (int k = 0; k < NB; k++) begin
         cyc(0, 1, k, 0, 0);
         chk("reset_read", data_out, 8'h40);
      end

      for (int k = 0; k < NB; k++) cyc(1, 0, k, 2 * k, 0);
      repeat (5) cyc(0, 0, 0, 0, 1);
      chk("shadow_iso", gains, all40);
      cyc(0, 1, 3, 0, 0);
      chk("shadow_rb3", data_out, 8'h06);

      cyc(1, 0, 0, 8'h48, 0);
      for (int k = 1; k < NB; k++) cyc(1, 0, k, 8'h40, 0);
      cyc(1, 0, NB, 1, 0);
      chk("commit_busy", busy, 1'b1);
      cyc(0, 0, 0, 0, 1);
      chk("tick1_b0", gains[7:0], 8'h40);
      cyc(0, 0, 0, 0, 1);
      chk("tick2_b0", gains[7:0], 8'h44);
      cyc(0, 0, 0, 0, 1);
      chk("tick3_b0", gains[7:0], 8'h48);
      chk("tick3_busy", busy, 1'b0);
      chk("tick3_rest", gains[NB*GW-1:8], rest40);

      cyc(1, 0, 1, 8'h20, 0);
      cyc(1, 0, NB, 1, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      chk("dn_b1", gains[15:8], 8'h3c);
      cyc(1, 0, 1, 8'h60, 0);
      cyc(1, 0, NB, 1, 0);
      cyc(0, 1, NB, 0, 0);
      chk("pend_status", data_out, 8'h06);
      for (int i = 0; i < 60 && busy; i++) cyc(0, 0, 0, 0, 1);
      chk("ramp_bound", busy, 1'b0);
      chk("up_b1", gains[15:8], 8'h60);

      cyc(1, 0, 8'h20, 8'h55, 0);
      chk("err_set", addr_err, 1'b1);
      cyc(0, 1, 8'h20, 0, 0);
      chk("err_read", data_out, 8'h00);
      cyc(1, 0, NB, 2, 0);
      chk("err_clr", addr_err, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) wa = $urandom_range(NB + 1, 255);
         else wa = $urandom_range(0, NB);
         wd = (wa == NB) ? $urandom_range(0, 3) : $urandom_range(0, 255);
         cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             wa, wd, $urandom_range(0, 3) == 0);
      end

      for (int i = 0; i < 80 && busy; i++) cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 8'h00, 0);
      cyc(1, 0, NB, 1, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      chk("pre_rst_busy", busy, 1'b1);
      we = 1'b0;
      re = 1'b0;
      sample_tick = 1'b0;
      @(posedge clk);
      model(0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_gains", gains, all40);
      chk("arst_busy", busy, 1'b0);
      chk("arst_err", addr_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 1, NB, 0, 0);
      chk("arst_status", data_out, 8'h00);
      cyc(0, 1, 0, 0, 0);
      chk("arst_shadow", data_out, 8'h40);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
